// File: rtl/tcb_layer2_seq_argmax.sv
// Sequencer for the 16->10 TCB output layer: launches the layer, captures its scores and
// scans them serially for the argmax class. Define SCORE_OUT_EN to add the o_out_score port.
module tcb_layer2_seq_argmax #(
   parameter int N_IN    = 16,
   parameter int IN_W    = 19,
   parameter int N_OUT   = 10,
   parameter int OUT_W   = 28,
   parameter int CLS_W   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_in_valid,
   output logic                   o_in_ready,
   input  logic [N_IN*IN_W-1:0]   i_in_data,
   output logic                   o_layer_valid,
   output logic [N_IN*IN_W-1:0]   o_layer_in,
   input  logic                   i_layer_ready,
   input  logic [N_OUT*OUT_W-1:0] i_layer_out,
   output logic                   o_out_valid,
   input  logic                   i_out_ready,
   output logic [CLS_W-1:0]       o_out_class,
   output logic                   o_out_err,
   output logic                   o_busy
`ifdef SCORE_OUT_EN
   ,
   output logic [OUT_W-1:0]       o_out_score
`endif
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(N_OUT - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_SCAN,
      S_DONE
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [N_IN*IN_W-1:0]  r_layer_in;
   logic [OUT_W-1:0]      r_scores [N_OUT];
   logic [OUT_W-1:0]      r_best_val;
   logic [CLS_W-1:0]      r_best_idx;
   logic [CLS_W-1:0]      r_scan_idx;
   logic [TMO_W-1:0]      r_tmo_cnt;
   logic                  r_out_err;

   logic                  w_accept;
   logic                  w_tmo_hit;
   logic                  w_scan_last;
   logic [OUT_W-1:0]      w_score_j;
   logic                  w_better;

   assign w_accept    = (r_state == S_IDLE) && i_in_valid && !i_rst;
   assign w_tmo_hit   = !i_layer_ready && (r_tmo_cnt == TMO_LAST);
   assign w_scan_last = (r_scan_idx == LAST_IDX);
   assign w_score_j   = r_scores[r_scan_idx];
   // Strict greater-than keeps the lower index on ties.
   assign w_better    = $signed(w_score_j) > $signed(r_best_val);

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      // NOTE: default assigned first so every path drives w_next and no latch is inferred.
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_next = S_LAUNCH;
         S_LAUNCH: w_next = S_WAIT;
         S_WAIT:   if (i_layer_ready || w_tmo_hit) w_next = i_layer_ready ? S_SCAN : S_DONE;
         S_SCAN:   if (w_scan_last) w_next = S_DONE;
         S_DONE:   if (i_out_ready) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_layer_in <= '0;
         // NOTE: the score bank is small and is cleared with everything else, so a reset
         // leaves no stale scores behind.
         for (int j = 0; j < N_OUT; j++) r_scores[j] <= '0;
         r_best_val <= '0;
         r_best_idx <= '0;
         r_scan_idx <= '0;
         r_tmo_cnt  <= '0;
         r_out_err  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         if (w_accept) begin
            r_layer_in <= i_in_data;
            r_out_err  <= 1'b0;
         end
         case (r_state)
            S_LAUNCH: r_tmo_cnt <= '0;
            S_WAIT: begin
               if (i_layer_ready) begin
                  for (int j = 0; j < N_OUT; j++) r_scores[j] <= i_layer_out[j*OUT_W +: OUT_W];
                  r_best_val <= i_layer_out[0 +: OUT_W];
                  r_best_idx <= '0;
                  r_scan_idx <= CLS_W'(1);
               end else if (w_tmo_hit) begin
                  r_out_err  <= 1'b1;
                  r_best_idx <= '1;
                  r_best_val <= '0;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
               end
            end
            S_SCAN: begin
               if (w_better) begin
                  r_best_val <= w_score_j;
                  r_best_idx <= r_scan_idx;
               end
               r_scan_idx <= r_scan_idx + CLS_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign o_in_ready    = (r_state == S_IDLE) && !i_rst;
   assign o_layer_valid = (r_state == S_LAUNCH);
   assign o_layer_in    = r_layer_in;
   assign o_out_valid   = (r_state == S_DONE);
   assign o_out_class   = r_best_idx;
   assign o_out_err     = r_out_err;
   assign o_busy        = (r_state != S_IDLE);
`ifdef SCORE_OUT_EN
   assign o_out_score   = r_best_val;
`endif

endmodule
